m2_state_reg_ff: RTL and testbench

- Parametrised SHA-2 working-state register (a..h) for the m2 hashing pipeline.
- Loads the initial value from the standard IV, an external midstate, or the previous digest (chaining).
- Shifts the working state once per enabled round and counts rounds.
- Performs the final feed-forward add itself, presenting a registered digest with a start/done handshake.

---
 rtl/m2_sha2_pkg.sv | 37 +++
 rtl/m2_word_add8.sv | 17 +
 rtl/m2_state_reg_ff.sv | 129 ++++++++++++
 tb/tb_m2_state_reg_ff.sv | 476 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m2_sha2_pkg.sv
// Shared SHA-2 constants, iv_sel encodings and the FSM state type for the
// m2 working-state register.
package m2_sha2_pkg;

  localparam int NWORDS = 8;

  localparam logic [31:0] IV256 [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [63:0] IV512 [0:7] = '{
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b,
    64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
    64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
  };

  localparam logic [1:0] IVSEL_STD   = 2'd0;
  localparam logic [1:0] IVSEL_MID   = 2'd1;
  localparam logic [1:0] IVSEL_CHAIN = 2'd2;
  localparam logic [1:0] IVSEL_RSVD  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FF   = 2'd2,
    ST_DONE = 2'd3
  } m2_state_e;

  // Word i (0 = a) of the standard IV, right-aligned in 64 bits.
  function automatic logic [63:0] iv_word(input int w, input logic [2:0] i);
    if (w == 32) return {32'h0, IV256[i]};
    return IV512[i];
  endfunction

endpackage

// File: rtl/m2_word_add8.sv
// Eight independent W-bit modular adders (chain + state); no carry crosses
// a word boundary.
module m2_word_add8
  import m2_sha2_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [NWORDS*W-1:0] i_chain,
  input  logic [NWORDS*W-1:0] i_state,
  output logic [NWORDS*W-1:0] o_sum
);

  for (genvar gi = 0; gi < NWORDS; gi++) begin : g_word
    assign o_sum[gi*W +: W] = i_chain[gi*W +: W] + i_state[gi*W +: W];
  end

endmodule

// File: rtl/m2_state_reg_ff.sv
// SHA-2 working-state register a..h: loads IV/midstate/chain, shifts once per
// enabled round, then performs the feed-forward add into a registered digest.
module m2_state_reg_ff
  import m2_sha2_pkg::*;
#(
  parameter int W      = 32,
  parameter int ROUNDS = 64,
  parameter int CW     = $clog2(ROUNDS + 1)
) (
  input  logic            clk_h,
  input  logic            rst_n,
  input  logic            clk_h_en,
  input  logic            start,
  input  logic            abort,
  input  logic [1:0]      iv_sel,
  input  logic [8*W-1:0]  mid_data,
  input  logic [W-1:0]    a_new,
  input  logic [W-1:0]    e_new,
  output logic [8*W-1:0]  state_out,
  output logic [CW-1:0]   round_idx,
  output logic            busy,
  output logic            done,
  output logic [8*W-1:0]  digest,
  output logic            digest_valid
);

  if (W != 32 && W != 64) begin : g_bad_width
    $error("m2_state_reg_ff: W must be 32 or 64");
  end

  localparam logic [CW-1:0] LAST_ROUND = CW'(ROUNDS - 1);

  logic [8*W-1:0] w_iv;
  logic [8*W-1:0] w_init;
  logic [8*W-1:0] w_shift;
  logic [8*W-1:0] w_sum;

  m2_state_e      r_fsm;
  logic [8*W-1:0] r_state;
  logic [8*W-1:0] r_chain;
  logic [8*W-1:0] r_digest;
  logic [CW-1:0]  r_round;
  logic           r_busy;
  logic           r_done;
  logic           r_valid;

  for (genvar gi = 0; gi < NWORDS; gi++) begin : g_iv
    localparam logic [63:0] IVW = iv_word(W, 3'(gi));
    assign w_iv[(NWORDS-1-gi)*W +: W] = IVW[W-1:0];
  end

  // Chaining reads the digest register as-is, even when it is not marked valid.
  always_comb begin
    w_init = w_iv;
    case (iv_sel)
      IVSEL_MID:   w_init = mid_data;
      IVSEL_CHAIN: w_init = r_digest;
      IVSEL_STD,
      IVSEL_RSVD:  w_init = w_iv;
      default:     w_init = w_iv;
    endcase
  end

  assign w_shift = {a_new, r_state[8*W-1:5*W], e_new, r_state[4*W-1:W]};

  m2_word_add8 #(.W(W)) u_add (
    .i_chain (r_chain),
    .i_state (r_state),
    .o_sum   (w_sum)
  );

  // abort outranks start and the round enable in every state.
  always_ff @(posedge clk_h or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm    <= ST_IDLE;
      r_state  <= '0;
      r_chain  <= '0;
      r_digest <= '0;
      r_round  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_fsm   <= ST_IDLE;
        r_busy  <= 1'b0;
        r_round <= '0;
        r_valid <= 1'b0;
      end else begin
        case (r_fsm)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              r_state <= w_init;
              r_chain <= w_init;
              r_round <= '0;
              r_valid <= 1'b0;
              r_busy  <= 1'b1;
              r_fsm   <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (clk_h_en) begin
              r_state <= w_shift;
              r_round <= r_round + CW'(1);
              if (r_round == LAST_ROUND) r_fsm <= ST_FF;
            end
          end
          ST_FF: begin
            r_digest <= w_sum;
            r_valid  <= 1'b1;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_fsm    <= ST_DONE;
          end
          default: r_fsm <= ST_IDLE;
        endcase
      end
    end
  end

  assign state_out    = r_state;
  assign round_idx    = r_round;
  assign busy         = r_busy;
  assign done         = r_done;
  assign digest       = r_digest;
  assign digest_valid = r_valid;

endmodule

// File: tb/tb_m2_state_reg_ff.sv
// Bench for m2_state_reg_ff: a W=32 and a W=64 instance driven with random
// round inputs and compared against a word-array model of the a..h register.
module tb_m2_state_reg_ff;

  localparam int R32 = 64;
  localparam int R64 = 80;

  logic clk_h = 1'b0;
  logic rst_n;

  // Free-running clock shared by both instances.
  always #5 clk_h = ~clk_h;

  logic         clkEn32, start32, abort32;
  logic [1:0]   ivSel32;
  logic [255:0] midData32, stateOut32, digest32;
  logic [31:0]  aNew32, eNew32;
  logic [6:0]   roundIdx32;
  logic         busy32, done32, digestValid32;

  logic         clkEn64, start64, abort64;
  logic [1:0]   ivSel64;
  logic [511:0] midData64, stateOut64, digest64;
  logic [63:0]  aNew64, eNew64;
  logic [6:0]   roundIdx64;
  logic         busy64, done64, digestValid64;

  m2_state_reg_ff #(.W(32), .ROUNDS(R32)) dut32 (
    .clk_h(clk_h), .rst_n(rst_n), .clk_h_en(clkEn32), .start(start32),
    .abort(abort32), .iv_sel(ivSel32), .mid_data(midData32),
    .a_new(aNew32), .e_new(eNew32), .state_out(stateOut32),
    .round_idx(roundIdx32), .busy(busy32), .done(done32),
    .digest(digest32), .digest_valid(digestValid32)
  );

  m2_state_reg_ff #(.W(64), .ROUNDS(R64)) dut64 (
    .clk_h(clk_h), .rst_n(rst_n), .clk_h_en(clkEn64), .start(start64),
    .abort(abort64), .iv_sel(ivSel64), .mid_data(midData64),
    .a_new(aNew64), .e_new(eNew64), .state_out(stateOut64),
    .round_idx(roundIdx64), .busy(busy64), .done(done64),
    .digest(digest64), .digest_valid(digestValid64)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: word 0 is a, word 7 is h; index [0] is the W=32 instance.
  logic [7:0][63:0] mState  [2];
  logic [7:0][63:0] mChain  [2];
  logic [7:0][63:0] mDigest [2];
  logic             mValid  [2];
  int               mRound  [2];

  function automatic logic [7:0][63:0] ivWords(input int d);
    logic [7:0][63:0] r;
    if (d == 0) begin
      r[0] = 64'h6a09e667; r[1] = 64'hbb67ae85; r[2] = 64'h3c6ef372; r[3] = 64'ha54ff53a;
      r[4] = 64'h510e527f; r[5] = 64'h9b05688c; r[6] = 64'h1f83d9ab; r[7] = 64'h5be0cd19;
    end else begin
      r[0] = 64'h6a09e667f3bcc908; r[1] = 64'hbb67ae8584caa73b;
      r[2] = 64'h3c6ef372fe94f82b; r[3] = 64'ha54ff53a5f1d36f1;
      r[4] = 64'h510e527fade682d1; r[5] = 64'h9b05688c2b3e6c1f;
      r[6] = 64'h1f83d9abfb41bd6b; r[7] = 64'h5be0cd19137e2179;
    end
    return r;
  endfunction

  function automatic logic [63:0] wmask(input int d);
    return (d == 0) ? 64'h0000_0000_ffff_ffff : 64'hffff_ffff_ffff_ffff;
  endfunction

  function automatic logic [511:0] pack(input int d, input logic [7:0][63:0] w);
    logic [511:0] r = '0;
    for (int i = 0; i < 8; i++) begin
      if (d == 0) r[(7-i)*32 +: 32] = w[i][31:0];
      else        r[(7-i)*64 +: 64] = w[i];
    end
    return r;
  endfunction

  function automatic logic [511:0] randMid();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [63:0] randWord(input int d);
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r & wmask(d);
  endfunction

  function automatic logic [511:0] obsState(input int d);
    return (d == 0) ? {256'h0, stateOut32} : stateOut64;
  endfunction

  function automatic logic [511:0] obsDigest(input int d);
    return (d == 0) ? {256'h0, digest32} : digest64;
  endfunction

  function automatic int obsRound(input int d);
    return (d == 0) ? int'(roundIdx32) : int'(roundIdx64);
  endfunction

  function automatic logic [2:0] obsFlags(input int d);
    return (d == 0) ? {busy32, done32, digestValid32} : {busy64, done64, digestValid64};
  endfunction

  task automatic tick();
    @(posedge clk_h);
    #1;
  endtask

  task automatic setIn(input int d, input logic en, input logic st, input logic ab,
                       input logic [1:0] sel, input logic [511:0] mid,
                       input logic [63:0] an, input logic [63:0] enw);
    if (d == 0) begin
      clkEn32 = en; start32 = st; abort32 = ab; ivSel32 = sel;
      midData32 = mid[255:0]; aNew32 = an[31:0]; eNew32 = enw[31:0];
    end else begin
      clkEn64 = en; start64 = st; abort64 = ab; ivSel64 = sel;
      midData64 = mid; aNew64 = an; eNew64 = enw;
    end
  endtask

  task automatic idleIn(input int d);
    setIn(d, 1'b0, 1'b0, 1'b0, 2'd0, '0, '0, '0);
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      mState[d] = '0; mChain[d] = '0; mDigest[d] = '0;
      mValid[d] = 1'b0; mRound[d] = 0;
    end
  endtask

  task automatic startBlock(input int d, input logic [1:0] sel, input logic [511:0] mid);
    logic [7:0][63:0] iv;
    logic [7:0][63:0] w;
    iv = ivWords(d);
    setIn(d, 1'b0, 1'b1, 1'b0, sel, mid, '0, '0);
    tick();
    idleIn(d);
    for (int i = 0; i < 8; i++) begin
      case (sel)
        2'd1:    w[i] = (d == 0) ? {32'h0, mid[(7-i)*32 +: 32]} : mid[(7-i)*64 +: 64];
        2'd2:    w[i] = mDigest[d][i];
        default: w[i] = iv[i];
      endcase
    end
    mState[d] = w;
    mChain[d] = w;
    mValid[d] = 1'b0;
    mRound[d] = 0;
  endtask

  // mode 0: zero inputs, 1: a_new=1/e_new=2, otherwise random. st drives a start request alongside.
  task automatic doRounds(input int d, input int n, input int mode, input logic st);
    logic [63:0] an;
    logic [63:0] enw;
    for (int k = 0; k < n; k++) begin
      case (mode)
        0:       begin an = '0; enw = '0; end
        1:       begin an = 64'd1; enw = 64'd2; end
        default: begin an = randWord(d); enw = randWord(d); end
      endcase
      setIn(d, 1'b1, st, 1'b0, 2'd1, randMid(), an, enw);
      tick();
      for (int i = 7; i > 0; i--) if (i != 4) mState[d][i] = mState[d][i-1];
      mState[d][0] = an & wmask(d);
      mState[d][4] = enw & wmask(d);
      mRound[d]++;
    end
    idleIn(d);
  endtask

  task automatic stallCycles(input int d, input int n);
    for (int k = 0; k < n; k++) begin
      setIn(d, 1'b0, 1'b0, 1'b0, 2'd1, randMid(), randWord(d), randWord(d));
      tick();
    end
    idleIn(d);
  endtask

  task automatic ffEdge(input int d, input logic ab);
    setIn(d, 1'($urandom % 2), 1'b0, ab, 2'd0, '0, randWord(d), randWord(d));
    tick();
    idleIn(d);
    if (ab) begin
      mValid[d] = 1'b0;
      mRound[d] = 0;
    end else begin
      for (int i = 0; i < 8; i++) mDigest[d][i] = (mChain[d][i] + mState[d][i]) & wmask(d);
      mValid[d] = 1'b1;
    end
  endtask

  task automatic doAbort(input int d);
    setIn(d, 1'b1, 1'b1, 1'b1, 2'd1, randMid(), randWord(d), randWord(d));
    tick();
    idleIn(d);
    mValid[d] = 1'b0;
    mRound[d] = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idleIn(0);
    idleIn(1);
    modelReset();
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (obsState(d) !== '0 || obsDigest(d) !== '0) begin
        miscompares++;
        $display("[TB] FAIL reset.data d=%0d state %h digest %h want all zero", d, obsState(d), obsDigest(d));
      end
      vectors++;
      if (obsFlags(d) !== 3'b000 || obsRound(d) !== 0) begin
        miscompares++;
        $display("[TB] FAIL reset.ctrl d=%0d busy/done/valid %b round %0d want 000 round 0", d, obsFlags(d), obsRound(d));
      end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_iv_zero();
    logic [511:0] ivp;
    ivp = pack(0, ivWords(0));
    startBlock(0, 2'd0, '0);
    vectors++;
    if (obsState(0) !== ivp) begin
      miscompares++; $display("[TB] FAIL iv_zero.load got %h want %h", obsState(0), ivp);
    end
    vectors++;
    if (obsFlags(0) !== 3'b100 || obsRound(0) !== 0) begin
      miscompares++; $display("[TB] FAIL iv_zero.load_ctrl flags %b round %0d want 100 round 0", obsFlags(0), obsRound(0));
    end
    doRounds(0, 4, 0, 1'b0);
    vectors++;
    if (obsState(0) !== '0) begin
      miscompares++; $display("[TB] FAIL iv_zero.flushed got %h want 0", obsState(0));
    end
    doRounds(0, R32 - 4, 0, 1'b0);
    vectors++;
    if (obsFlags(0) !== 3'b100 || obsRound(0) !== R32) begin
      miscompares++; $display("[TB] FAIL iv_zero.last_round flags %b round %0d want 100 round %0d", obsFlags(0), obsRound(0), R32);
    end
    ffEdge(0, 1'b0);
    vectors++;
    if (obsFlags(0) !== 3'b011 || obsDigest(0) !== ivp) begin
      miscompares++; $display("[TB] FAIL iv_zero.done flags %b digest %h want 011 %h", obsFlags(0), obsDigest(0), ivp);
    end
    tick();
    vectors++;
    if (obsFlags(0) !== 3'b001 || obsDigest(0) !== ivp) begin
      miscompares++; $display("[TB] FAIL iv_zero.hold flags %b digest %h want 001 %h", obsFlags(0), obsDigest(0), ivp);
    end
  endtask

  task automatic test_const_inputs();
    logic [511:0] dig;
    startBlock(0, 2'd0, '0);
    doRounds(0, R32, 1, 1'b0);
    vectors++;
    if (obsRound(0) !== R32) begin
      miscompares++; $display("[TB] FAIL const.round got %0d want %0d", obsRound(0), R32);
    end
    ffEdge(0, 1'b0);
    dig = obsDigest(0);
    vectors++;
    if (dig[255:224] !== 32'h6a09e668 || dig[127:96] !== 32'h510e5281) begin
      miscompares++; $display("[TB] FAIL const.words a %h e %h want 6a09e668 510e5281", dig[255:224], dig[127:96]);
    end
    vectors++;
    if (dig !== pack(0, mDigest[0]) || obsFlags(0) !== 3'b011) begin
      miscompares++; $display("[TB] FAIL const.digest flags %b got %h want 011 %h", obsFlags(0), dig, pack(0, mDigest[0]));
    end
  endtask

  task automatic test_chaining();
    startBlock(0, 2'd0, '0);
    doRounds(0, R32, 2, 1'b0);
    ffEdge(0, 1'b0);
    vectors++;
    if (obsDigest(0) !== pack(0, mDigest[0])) begin
      miscompares++; $display("[TB] FAIL chain.block1 got %h want %h", obsDigest(0), pack(0, mDigest[0]));
    end
    startBlock(0, 2'd2, randMid());
    vectors++;
    if (obsState(0) !== pack(0, mState[0])) begin
      miscompares++; $display("[TB] FAIL chain.load got %h want %h", obsState(0), pack(0, mState[0]));
    end
    doRounds(0, R32, 2, 1'b0);
    ffEdge(0, 1'b0);
    vectors++;
    if (obsDigest(0) !== pack(0, mDigest[0]) || obsFlags(0) !== 3'b011) begin
      miscompares++; $display("[TB] FAIL chain.block2 flags %b got %h want 011 %h", obsFlags(0), obsDigest(0), pack(0, mDigest[0]));
    end
  endtask

  task automatic test_stall();
    startBlock(0, 2'd0, '0);
    doRounds(0, 20, 2, 1'b0);
    stallCycles(0, 10);
    vectors++;
    if (obsRound(0) !== 20 || obsState(0) !== pack(0, mState[0])) begin
      miscompares++; $display("[TB] FAIL stall.hold round %0d state %h want 20 %h", obsRound(0), obsState(0), pack(0, mState[0]));
    end
    doRounds(0, R32 - 20, 2, 1'b0);
    vectors++;
    if (obsFlags(0) !== 3'b100) begin
      miscompares++; $display("[TB] FAIL stall.not_yet flags %b want 100", obsFlags(0));
    end
    ffEdge(0, 1'b0);
    vectors++;
    if (obsFlags(0) !== 3'b011 || obsDigest(0) !== pack(0, mDigest[0])) begin
      miscompares++; $display("[TB] FAIL stall.done flags %b got %h want 011 %h", obsFlags(0), obsDigest(0), pack(0, mDigest[0]));
    end
  endtask

  task automatic test_abort();
    logic [511:0] prev;
    logic [511:0] mid;
    logic [511:0] midExp;
    startBlock(0, 2'd0, '0);
    doRounds(0, 30, 2, 1'b0);
    prev = pack(0, mDigest[0]);
    doAbort(0);
    vectors++;
    if (obsFlags(0) !== 3'b000 || obsRound(0) !== 0 || obsDigest(0) !== prev) begin
      miscompares++; $display("[TB] FAIL abort.effect flags %b round %0d digest %h want 000 0 %h", obsFlags(0), obsRound(0), obsDigest(0), prev);
    end
    tick();
    vectors++;
    if (obsFlags(0) !== 3'b000) begin
      miscompares++; $display("[TB] FAIL abort.over_start flags %b want 000", obsFlags(0));
    end
    mid = randMid();
    midExp = mid;
    midExp[511:256] = '0;
    startBlock(0, 2'd1, mid);
    vectors++;
    if (obsState(0) !== midExp || obsFlags(0) !== 3'b100) begin
      miscompares++; $display("[TB] FAIL abort.reload flags %b got %h want 100 %h", obsFlags(0), obsState(0), midExp);
    end
    doRounds(0, R32, 2, 1'b0);
    vectors++;
    if (obsFlags(0) !== 3'b100) begin
      miscompares++; $display("[TB] FAIL abort.valid_low flags %b want 100", obsFlags(0));
    end
    ffEdge(0, 1'b0);
    vectors++;
    if (obsFlags(0) !== 3'b011 || obsDigest(0) !== pack(0, mDigest[0])) begin
      miscompares++; $display("[TB] FAIL abort.new_done flags %b got %h want 011 %h", obsFlags(0), obsDigest(0), pack(0, mDigest[0]));
    end
  endtask

  task automatic test_start_while_busy();
    startBlock(0, 2'd0, '0);
    doRounds(0, 10, 2, 1'b0);
    doRounds(0, 1, 2, 1'b1);
    vectors++;
    if (obsRound(0) !== 11 || obsState(0) !== pack(0, mState[0])) begin
      miscompares++; $display("[TB] FAIL busy_start.ignored round %0d state %h want 11 %h", obsRound(0), obsState(0), pack(0, mState[0]));
    end
    doRounds(0, R32 - 11, 2, 1'b0);
    ffEdge(0, 1'b0);
    vectors++;
    if (obsFlags(0) !== 3'b011 || obsDigest(0) !== pack(0, mDigest[0])) begin
      miscompares++; $display("[TB] FAIL busy_start.digest flags %b got %h want 011 %h", obsFlags(0), obsDigest(0), pack(0, mDigest[0]));
    end
  endtask

  task automatic test_abort_at_ff();
    logic [511:0] prev;
    startBlock(0, 2'd0, '0);
    doRounds(0, R32, 2, 1'b0);
    prev = pack(0, mDigest[0]);
    ffEdge(0, 1'b1);
    vectors++;
    if (obsFlags(0) !== 3'b000 || obsRound(0) !== 0 || obsDigest(0) !== prev) begin
      miscompares++; $display("[TB] FAIL abort_ff.effect flags %b round %0d digest %h want 000 0 %h", obsFlags(0), obsRound(0), obsDigest(0), prev);
    end
    tick();
    vectors++;
    if (obsFlags(0) !== 3'b000) begin
      miscompares++; $display("[TB] FAIL abort_ff.no_done flags %b want 000", obsFlags(0));
    end
  endtask

  task automatic test_iv_sel_reserved();
    logic [511:0] ivp;
    ivp = pack(0, ivWords(0));
    startBlock(0, 2'd3, randMid());
    vectors++;
    if (obsState(0) !== ivp || obsState(0) !== pack(0, mState[0])) begin
      miscompares++; $display("[TB] FAIL sel3.load got %h want %h", obsState(0), ivp);
    end
    doAbort(0);
    vectors++;
    if (obsFlags(0) !== 3'b000 || obsRound(0) !== 0) begin
      miscompares++; $display("[TB] FAIL sel3.abort flags %b round %0d want 000 0", obsFlags(0), obsRound(0));
    end
  endtask

  task automatic test_w64();
    logic [511:0] ivp;
    ivp = pack(1, ivWords(1));
    startBlock(1, 2'd0, '0);
    vectors++;
    if (obsState(1) !== ivp) begin
      miscompares++; $display("[TB] FAIL w64.load got %h want %h", obsState(1), ivp);
    end
    doRounds(1, R64, 0, 1'b0);
    vectors++;
    if (obsFlags(1) !== 3'b100 || obsRound(1) !== R64) begin
      miscompares++; $display("[TB] FAIL w64.last_round flags %b round %0d want 100 %0d", obsFlags(1), obsRound(1), R64);
    end
    ffEdge(1, 1'b0);
    vectors++;
    if (obsFlags(1) !== 3'b011 || obsDigest(1) !== ivp) begin
      miscompares++; $display("[TB] FAIL w64.done flags %b got %h want 011 %h", obsFlags(1), obsDigest(1), ivp);
    end
    startBlock(1, 2'd1, randMid());
    doRounds(1, 30, 2, 1'b0);
    vectors++;
    if (obsState(1) !== pack(1, mState[1]) || obsRound(1) !== 30) begin
      miscompares++; $display("[TB] FAIL w64.mid_run round %0d got %h want 30 %h", obsRound(1), obsState(1), pack(1, mState[1]));
    end
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (obsState(d) !== '0 || obsDigest(d) !== '0 || obsFlags(d) !== 3'b000 || obsRound(d) !== 0) begin
        miscompares++;
        $display("[TB] FAIL w64.async_reset d=%0d flags %b round %0d state %h want all zero", d, obsFlags(d), obsRound(d), obsState(d));
      end
    end
    @(posedge clk_h);
    #1;
    rst_n = 1'b1;
    startBlock(1, 2'd2, randMid());
    vectors++;
    if (obsState(1) !== '0) begin
      miscompares++; $display("[TB] FAIL w64.chain_after_reset got %h want 0", obsState(1));
    end
    doRounds(1, R64, 2, 1'b0);
    ffEdge(1, 1'b0);
    vectors++;
    if (obsFlags(1) !== 3'b011 || obsDigest(1) !== pack(1, mDigest[1])) begin
      miscompares++; $display("[TB] FAIL w64.random flags %b got %h want 011 %h", obsFlags(1), obsDigest(1), pack(1, mDigest[1]));
    end
  endtask

  // Scenarios run back to back on the W=32 instance, then the W=64 one.
  initial begin
    test_reset();
    test_iv_zero();
    test_const_inputs();
    test_chaining();
    test_stall();
    test_abort();
    test_start_while_busy();
    test_abort_at_ff();
    test_iv_sel_reserved();
    test_w64();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
